cpu_sprite_dma: RTL
===================

Name: cpu_sprite_dma

Overview:
Parametrised bus-mastering DMA engine for the 2a03 CPU complex, a generalisation of the fixed $4014 sprite DMA. It snoops CPU writes for a trigger register and halts the CPU. It then copies LEN bytes from page {written_value, 8'h00} to a destination port, with fixed or incrementing destination address. It sits between the CPU core and the system bus, and muxes address, data and rw onto the bus.

Parameters:
LEN, 256, bytes per transfer (1..256); the source index is 8 bits
TRIGGER_ADDR, 16'h4014, CPU write address that starts a transfer
DEST_ADDR, 16'h2004, first destination address
DEST_INCR, 0, 0 = fixed destination; 1 = destination increments per byte and wraps at 16 bits
PARITY_ALIGN, 1, 1 = source reads occur only on even phase; 0 = no extra alignment cycle

Ports:
clock  in  1  system CPU clock
reset  in  1  synchronous, active-high
cpu_addr  in  16  CPU address bus request
cpu_data_out  in  8  CPU write data
cpu_rw  in  1  CPU rw (0 = write, 1 = read)
data_in  in  8  system data bus to master
addr  out  16  system address bus
data_out  out  8  system write data
rw  out  1  system rw
cpu_halt  out  1  1 = CPU must hold all state this cycle
busy  out  1  transfer in progress (= cpu_halt)
done  out  1  one-cycle pulse on the cycle after the last write

Behaviour:
- Reset values:
  - state IDLE, phase 0, cpu_halt 0, busy 0, done 0.
  - Bus outputs pass through the CPU: addr = cpu_addr, data_out = cpu_data_out, rw = cpu_rw.
- phase: a 1-bit register, 0 after reset, toggling every clock unconditionally.
- Trigger:
  - Condition: state IDLE, cpu_rw == 0 and cpu_addr == TRIGGER_ADDR on cycle T.
  - On T: latch page <= cpu_data_out and trig_phase <= phase.
  - The CPU write itself completes on the bus at T.
  - A trigger match while not IDLE is ignored.
- States: IDLE, DUMMY, ALIGN, READ, WRITE.
  - IDLE -> DUMMY on trigger.
  - DUMMY (T+1): asserts cpu_halt; rw = 1; addr = cpu_addr.
  - DUMMY -> ALIGN if PARITY_ALIGN and phase == 0 during DUMMY (i.e. trigger on odd phase); otherwise DUMMY -> READ.
  - ALIGN: one cycle, same bus drive as DUMMY; then -> READ.
  - READ: addr = {page, idx}; rw = 1; latch byte <= data_in at end of cycle; -> WRITE.
  - WRITE: addr = dest; rw = 0; data_out = byte. Then idx <= idx + 1, and dest <= dest + DEST_INCR.
  - WRITE -> READ if idx != LEN-1; otherwise -> IDLE and pulse done.
- Cycle count with cpu_halt = 1:
  - Even-phase trigger: 1 + 2*LEN (513 at default).
  - Odd-phase trigger: 2 + 2*LEN (514). With PARITY_ALIGN = 0, always 1 + 2*LEN.
- cpu_halt is a registered output: high from T+1 through the last WRITE inclusive.
- Width rules:
  - idx is 8 bits; source address = {page, idx}, never crossing into the next page.
  - dest is 16 bits and wraps $FFFF -> $0000.
  - LEN = 256 terminates on idx == 8'hFF.
- Bus mux: registered state selects the DMA or CPU drive; the output mux is combinational.
- Reset mid-transfer:
  - Next cycle is IDLE with cpu_halt 0 and no done pulse.
  - Partial writes already issued stand; idx and dest are cleared.
- Reset asserted on a trigger cycle: reset wins and no transfer starts.
- The CPU must not change addr, rw or data_out while cpu_halt = 1. Its inputs are ignored in all non-IDLE states.

Decomposition:
- Shared package/include (alongside the existing control-value defines):
  - State encoding constants DMA_ST_IDLE..DMA_ST_WRITE.
  - Default TRIGGER_ADDR / DEST_ADDR constants.
  - RW_READ / RW_WRITE reuse the existing definitions.
- One natural sub-module, cpu_dma_bus_mux: combinational select of addr, data_out and rw between the CPU and the DMA engine. The FSM and counters stay in cpu_sprite_dma.

Test Plan:
- Even-phase trigger with default parameters: CPU writes 8'h02 to $4014 at phase 0.
  - cpu_halt high exactly 513 cycles.
  - Reads $0200..$02FF in order, each followed by a write to $2004 of the byte read.
  - done pulses once; CPU passthrough resumes.
- Odd-phase trigger with the same write at phase 1: exactly 514 halted cycles, and the first READ occurs on phase 0.
- LEN=4, DEST_INCR=1, DEST_ADDR=16'hFFFE, page 8'h07, memory $0700..$0703 = AA,BB,CC,DD:
  - Writes $FFFE=AA, $FFFF=BB, $0000=CC, $0001=DD.
  - 9 or 10 halted cycles depending on trigger phase.
- Non-trigger accesses:
  - CPU read of $4014 (rw = 1): no transfer.
  - CPU write to $4015: no transfer.
  - Bus outputs equal the CPU inputs every cycle.
- Reset after the 10th WRITE of a default transfer: next cycle IDLE, cpu_halt 0, no done pulse. A following trigger runs a full 513/514-cycle transfer from idx 0.
- Trigger-address write while in READ state (forced on cpu_* inputs): ignored. page is unchanged and the transfer length is unchanged.

Source files
------------

// File: rtl/cpu_sprite_dma_pkg.sv
// Shared constants for the 2a03 sprite/page DMA engine: state encoding,
// default trigger/destination addresses and bus rw encoding.
package cpu_sprite_dma_pkg;

   typedef enum logic [2:0] {
      DMA_ST_IDLE  = 3'd0,
      DMA_ST_DUMMY = 3'd1,
      DMA_ST_ALIGN = 3'd2,
      DMA_ST_READ  = 3'd3,
      DMA_ST_WRITE = 3'd4
   } dma_state_e;

   localparam logic [15:0] DMA_TRIGGER_ADDR_DEF = 16'h4014;
   localparam logic [15:0] DMA_DEST_ADDR_DEF    = 16'h2004;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/cpu_dma_bus_mux.sv
// Combinational system-bus select between the CPU core and the DMA engine.
module cpu_dma_bus_mux (
   input  logic        dma_sel_i,
   input  logic [15:0] cpu_addr_i,
   input  logic [7:0]  cpu_data_i,
   input  logic        cpu_rw_i,
   input  logic [15:0] dma_addr_i,
   input  logic [7:0]  dma_data_i,
   input  logic        dma_rw_i,
   output logic [15:0] addr_o,
   output logic [7:0]  data_o,
   output logic        rw_o
);

   always_comb begin
      addr_o = cpu_addr_i;
      data_o = cpu_data_i;
      rw_o   = cpu_rw_i;
      if (dma_sel_i) begin
         addr_o = dma_addr_i;
         data_o = dma_data_i;
         rw_o   = dma_rw_i;
      end
   end

endmodule

// File: rtl/cpu_sprite_dma.sv
// Bus-mastering page-copy DMA: snoops a CPU write to the trigger register,
// halts the CPU and copies LEN bytes from {page, idx} to the destination port.
//
// state | meaning
// IDLE  | CPU owns the bus, snooping for a trigger write
// DUMMY | first halted cycle, CPU address driven as a read
// ALIGN | extra halted cycle so source reads land on even phase
// READ  | read source byte {page, idx}
// WRITE | write latched byte to dest, advance idx/dest
module cpu_sprite_dma
   import cpu_sprite_dma_pkg::*;
#(
   parameter int          LEN          = 256,
   parameter logic [15:0] TRIGGER_ADDR = DMA_TRIGGER_ADDR_DEF,
   parameter logic [15:0] DEST_ADDR    = DMA_DEST_ADDR_DEF,
   parameter bit          DEST_INCR    = 1'b0,
   parameter bit          PARITY_ALIGN = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_out,
   input  logic        cpu_rw,
   input  logic [7:0]  data_in,
   output logic [15:0] addr,
   output logic [7:0]  data_out,
   output logic        rw,
   output logic        cpu_halt,
   output logic        busy,
   output logic        done
);

   localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

   dma_state_e  state_q, state_d;
   logic        phase_q;
   logic        trig_phase_q, trig_phase_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  idx_q, idx_d;
   logic [15:0] dest_q, dest_d;
   logic [7:0]  byte_q, byte_d;
   logic        halt_q, halt_d;
   logic        done_q, done_d;

   logic [15:0] dma_addr;
   logic        dma_rw;
   logic        dma_sel;

   always_comb begin
      state_d      = state_q;
      trig_phase_d = trig_phase_q;
      page_d       = page_q;
      idx_d        = idx_q;
      dest_d       = dest_q;
      byte_d       = byte_q;
      done_d       = 1'b0;
      dma_addr     = cpu_addr;
      dma_rw       = RW_READ;

      unique case (state_q)
         DMA_ST_IDLE: begin
            if (cpu_rw == RW_WRITE && cpu_addr == TRIGGER_ADDR) begin
               state_d      = DMA_ST_DUMMY;
               page_d       = cpu_data_out;
               trig_phase_d = phase_q;
               idx_d        = 8'h00;
               dest_d       = DEST_ADDR;
            end
         end
         // An odd-phase trigger makes DUMMY land on phase 0; ALIGN pushes READ to phase 0.
         DMA_ST_DUMMY: state_d = (PARITY_ALIGN && trig_phase_q) ? DMA_ST_ALIGN : DMA_ST_READ;
         DMA_ST_ALIGN: state_d = DMA_ST_READ;
         DMA_ST_READ: begin
            dma_addr = {page_q, idx_q};
            byte_d   = data_in;
            state_d  = DMA_ST_WRITE;
         end
         DMA_ST_WRITE: begin
            dma_addr = dest_q;
            dma_rw   = RW_WRITE;
            if (idx_q == LAST_IDX) begin
               state_d = DMA_ST_IDLE;
               done_d  = 1'b1;
               idx_d   = 8'h00;
               dest_d  = DEST_ADDR;
            end else begin
               state_d = DMA_ST_READ;
               idx_d   = idx_q + 8'd1;
               dest_d  = dest_q + {15'd0, DEST_INCR};
            end
         end
         default: state_d = DMA_ST_IDLE;
      endcase

      halt_d = (state_d != DMA_ST_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= DMA_ST_IDLE;
         phase_q      <= 1'b0;
         trig_phase_q <= 1'b0;
         page_q       <= 8'h00;
         idx_q        <= 8'h00;
         dest_q       <= DEST_ADDR;
         byte_q       <= 8'h00;
         halt_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= ~phase_q;
         trig_phase_q <= trig_phase_d;
         page_q       <= page_d;
         idx_q        <= idx_d;
         dest_q       <= dest_d;
         byte_q       <= byte_d;
         halt_q       <= halt_d;
         done_q       <= done_d;
      end
   end

   assign dma_sel  = (state_q != DMA_ST_IDLE);
   assign cpu_halt = halt_q;
   assign busy     = halt_q;
   assign done     = done_q;

   cpu_dma_bus_mux u_bus_mux (
      .dma_sel_i  (dma_sel),
      .cpu_addr_i (cpu_addr),
      .cpu_data_i (cpu_data_out),
      .cpu_rw_i   (cpu_rw),
      .dma_addr_i (dma_addr),
      .dma_data_i (byte_q),
      .dma_rw_i   (dma_rw),
      .addr_o     (addr),
      .data_o     (data_out),
      .rw_o       (rw)
   );

endmodule
